// File: rtl/ram_ctrl_pkg.sv
// Shared types for the RAM access controller: FSM states, queued command record, default widths.
package ram_ctrl_pkg;

    localparam int DEF_ADSIZE = 4;
    localparam int DEF_DASIZE = 16;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE_WR,
        ISSUE_RD,
        RD_WAIT,
        RSP
    } state_e;

    typedef struct packed {
        logic                  we;
        logic [DEF_ADSIZE-1:0] addr;
        logic [DEF_DASIZE-1:0] wdata;
    } cmd_t;

endpackage

// File: rtl/ram_cmd_fifo.sv
// In-order command FIFO, DEPTH x cmd_t, synchronous active-high reset flushes pointers and count.
module ram_cmd_fifo
    import ram_ctrl_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  cmd_t                     push_data,
    input  logic                     pop,
    output cmd_t                     head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] DEPTH_C = (PTR_W + 1)'(DEPTH);

    cmd_t             mem_q [DEPTH];
    cmd_t             mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             do_push, do_pop;

    assign full    = (count_q == DEPTH_C);
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign head    = mem_q[rd_ptr_q];
    // Fullness comes from the registered count, so a same-cycle pop never makes room for a push.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/ram_access_ctrl.sv
// Request stage for the 16x16 single-port data RAM: command FIFO, access sequencer, read response channel.
// Optional RAM_CTRL_STATS_EN adds saturating write/read issue counters stat_wr_cnt / stat_rd_cnt.
module ram_access_ctrl
    import ram_ctrl_pkg::*;
#(
    parameter int ADSize   = DEF_ADSIZE,
    parameter int DASize   = DEF_DASIZE,
    parameter int CQ_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADSize-1:0] req_addr,
    input  logic [DASize-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DASize-1:0] rsp_rdata,
    output logic              ram_en_read,
    output logic              ram_en_write,
    output logic [ADSize-1:0] ram_addr,
    output logic [DASize-1:0] ram_din,
    input  logic [DASize-1:0] ram_dout,
    output logic              busy
`ifdef RAM_CTRL_STATS_EN
    ,
    output logic [15:0]       stat_wr_cnt,
    output logic [15:0]       stat_rd_cnt
`endif
);

    localparam int CNT_W = $clog2(CQ_DEPTH) + 1;

    state_e            state_q, state_d;
    logic [ADSize-1:0] addr_q, addr_d;
    logic [DASize-1:0] din_q, din_d;
    logic [DASize-1:0] rdata_q, rdata_d;
    logic              en_rd_q, en_rd_d;
    logic              en_wr_q, en_wr_d;
    logic              rsp_valid_q, rsp_valid_d;

    cmd_t              fifo_in, fifo_head;
    logic              fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [CNT_W-1:0]  fifo_count;

    assign fifo_in   = '{we: req_we, addr: req_addr, wdata: req_wdata};
    assign req_ready = !rst && !fifo_full;
    assign fifo_push = req_valid && req_ready;

    ram_cmd_fifo #(
        .DEPTH (CQ_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (fifo_push),
        .push_data (fifo_in),
        .pop       (fifo_pop),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        din_d    = din_q;
        rdata_d  = rdata_q;
        fifo_pop = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    addr_d   = fifo_head.addr;
                    if (fifo_head.we) begin
                        din_d   = fifo_head.wdata;
                        state_d = ISSUE_WR;
                    end else begin
                        state_d = ISSUE_RD;
                    end
                end
            end
            ISSUE_WR: state_d = IDLE;
            ISSUE_RD: state_d = RD_WAIT;
            RD_WAIT: begin
                rdata_d = ram_dout;
                state_d = RSP;
            end
            RSP: begin
                if (rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // RAM strobes and rsp_valid are flops keyed on the next state, so they never glitch.
        en_wr_d     = (state_d == ISSUE_WR);
        en_rd_d     = (state_d == ISSUE_RD);
        rsp_valid_d = (state_d == RSP);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            din_q       <= '0;
            rdata_q     <= '0;
            en_rd_q     <= 1'b0;
            en_wr_q     <= 1'b0;
            rsp_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            din_q       <= din_d;
            rdata_q     <= rdata_d;
            en_rd_q     <= en_rd_d;
            en_wr_q     <= en_wr_d;
            rsp_valid_q <= rsp_valid_d;
        end
    end

    // Gating with rst keeps the RAM quiet and the response channel idle during the reset cycle itself.
    assign ram_en_read  = en_rd_q && !rst;
    assign ram_en_write = en_wr_q && !rst;
    assign ram_addr     = addr_q;
    assign ram_din      = din_q;
    assign rsp_valid    = rsp_valid_q && !rst;
    assign rsp_rdata    = rdata_q;
    assign busy         = !rst && ((fifo_count != '0) || (state_q != IDLE));

`ifdef RAM_CTRL_STATS_EN
    logic [15:0] stat_wr_q, stat_wr_d;
    logic [15:0] stat_rd_q, stat_rd_d;

    always_comb begin
        stat_wr_d = stat_wr_q;
        stat_rd_d = stat_rd_q;
        if (en_wr_q && (stat_wr_q != 16'hFFFF)) stat_wr_d = stat_wr_q + 16'd1;
        if (en_rd_q && (stat_rd_q != 16'hFFFF)) stat_rd_d = stat_rd_q + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stat_wr_q <= '0;
            stat_rd_q <= '0;
        end else begin
            stat_wr_q <= stat_wr_d;
            stat_rd_q <= stat_rd_d;
        end
    end

    assign stat_wr_cnt = stat_wr_q;
    assign stat_rd_cnt = stat_rd_q;
`endif

endmodule

// File: tb/tb_ram_access_ctrl.sv
// Bench for ram_access_ctrl with a behavioural 16x16 RAM; vector table, corner sequences, random traffic.
`timescale 1ns/1ps
module tb_ram_access_ctrl;

    // Handshake rule used throughout: a transfer happens on the posedge where valid && ready are both high.

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_we;
    logic [3:0]  req_addr;
    logic [15:0] req_wdata;
    logic        rsp_valid, rsp_ready;
    logic [15:0] rsp_rdata;
    logic        ram_en_read, ram_en_write;
    logic [3:0]  ram_addr;
    logic [15:0] ram_din, ram_dout;
    logic        busy;
`ifdef RAM_CTRL_STATS_EN
    logic [15:0] stat_wr_cnt, stat_rd_cnt;
`endif

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          rsp_count = 0;
    int          rsp_mode = 0;   // 0: always ready, 1: never ready, 2: random
    logic [15:0] last_rsp;
    logic [15:0] exp_q[$];
    logic [15:0] model_mem [16];
    int          wr_cyc_q[$];
    logic        track_wr = 1'b0;
    logic        hold_prev = 1'b0;
    logic [15:0] hold_data;
    logic [15:0] exp_val;

    typedef struct {
        logic        we;
        logic [3:0]  addr;
        logic [15:0] wdata;
        logic [15:0] exp_rdata;
    } vec_t;
    vec_t vecs [10];

    ram_access_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_rdata    (rsp_rdata),
        .ram_en_read  (ram_en_read),
        .ram_en_write (ram_en_write),
        .ram_addr     (ram_addr),
        .ram_din      (ram_din),
        .ram_dout     (ram_dout),
        .busy         (busy)
`ifdef RAM_CTRL_STATS_EN
        ,
        .stat_wr_cnt  (stat_wr_cnt),
        .stat_rd_cnt  (stat_rd_cnt)
`endif
    );

    // ---------------- clock / reset / RAM ----------------
    initial forever #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    logic [15:0] ram_mem [16];
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 16; i++) ram_mem[i] <= 16'h0000;
            ram_dout <= 16'h0000;
        end else begin
            if (ram_en_write) ram_mem[ram_addr] <= ram_din;
            if (ram_en_read)  ram_dout <= ram_mem[ram_addr];
        end
    end

    initial begin
        rsp_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (rsp_mode)
                0:       rsp_ready = 1'b1;
                1:       rsp_ready = 1'b0;
                default: rsp_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard / monitor ----------------
    always @(negedge clk) begin
        if (ram_en_read && ram_en_write) begin
            errors++;
            $display("FAIL ram_en_excl: en_read=1 en_write=1 at cycle %0d, required never both", cyc);
        end
        if (track_wr && ram_en_write) wr_cyc_q.push_back(cyc);
        if (hold_prev && rsp_valid) begin
            checks++;
            if (rsp_rdata !== hold_data) begin
                errors++;
                $display("FAIL rsp_stable: rdata %h changed, required %h", rsp_rdata, hold_data);
            end
        end
        if (rsp_valid && rsp_ready) begin
            rsp_count++;
            last_rsp = rsp_rdata;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL rsp_unexpected: got response %h, required none", rsp_rdata);
            end else begin
                exp_val = exp_q.pop_front();
                if (rsp_rdata !== exp_val) begin
                    errors++;
                    $display("FAIL rsp_data: got %h required %h", rsp_rdata, exp_val);
                end
            end
        end
        hold_prev = rsp_valid && !rsp_ready;
        hold_data = rsp_rdata;
    end

    // ---------------- driver tasks ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    task automatic reset_dut();
        rst       = 1'b1;
        req_valid = 1'b0;
        exp_q.delete();
        for (int i = 0; i < 16; i++) model_mem[i] = 16'h0000;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    // Called at a negedge; returns at the negedge following the accepting posedge.
    task automatic send(input logic we, input logic [3:0] a, input logic [15:0] d);
        int n = 0;
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = a;
        req_wdata = d;
        while (!req_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            checks++;
            errors++;
            $display("FAIL req_accept_timeout: req_ready=0 after %0d cycles, required 1", n);
            req_valid = 1'b0;
            return;
        end
        @(negedge clk);
        if (we) model_mem[a] = d;
        else    exp_q.push_back(model_mem[a]);
        req_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((busy || exp_q.size() != 0) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (busy || exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL idle_timeout: busy=%0d pending=%0d, required 0 0", busy, exp_q.size());
        end
    endtask

    // ---------------- test sequence ----------------
    initial begin
        int n0;
        int lat;
        int bad;
        rst       = 1'b1;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_addr  = '0;
        req_wdata = '0;

        vecs[0] = '{1'b0, 4'd7,  16'h0000, 16'h0000};
        vecs[1] = '{1'b1, 4'd3,  16'hBEEF, 16'h0000};
        vecs[2] = '{1'b0, 4'd3,  16'h0000, 16'hBEEF};
        vecs[3] = '{1'b1, 4'd0,  16'h1234, 16'h0000};
        vecs[4] = '{1'b1, 4'd15, 16'hABCD, 16'h0000};
        vecs[5] = '{1'b0, 4'd15, 16'h0000, 16'hABCD};
        vecs[6] = '{1'b0, 4'd0,  16'h0000, 16'h1234};
        vecs[7] = '{1'b1, 4'd3,  16'h5A5A, 16'h0000};
        vecs[8] = '{1'b0, 4'd3,  16'h0000, 16'h5A5A};
        vecs[9] = '{1'b1, 4'd3,  16'hBEEF, 16'h0000};

        // reset values, sampled while rst is held
        repeat (3) @(negedge clk);
        chk("rst_req_ready", req_ready, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_rdata", rsp_rdata, 0);
        chk("rst_en_read", ram_en_read, 0);
        chk("rst_en_write", ram_en_write, 0);
        chk("rst_ram_addr", ram_addr, 0);
        chk("rst_ram_din", ram_din, 0);
        chk("rst_busy", busy, 0);
        reset_dut();
        chk("post_rst_req_ready", req_ready, 1);

        // vector table: read-after-reset, write/read pairs, overwrite
        for (int i = 0; i < 10; i++) begin
            n0 = rsp_count;
            send(vecs[i].we, vecs[i].addr, vecs[i].wdata);
            if (!vecs[i].we) begin
                lat = 0;
                while (rsp_count == n0 && lat < 50) begin
                    @(negedge clk);
                    lat++;
                end
                chk($sformatf("vec%0d_rdata", i), (rsp_count == n0) ? 32'hDEAD_0000 : {16'h0, last_rsp},
                    {16'h0, vecs[i].exp_rdata});
            end
        end

        // read latency from idle: rsp_valid rises three edges after the accept edge
        wait_idle();
        send(1'b0, 4'd3, 16'h0000);
        lat = 0;
        while (!rsp_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk("rd_latency", lat, 3);
        chk("rd_latency_data", rsp_rdata, 16'hBEEF);
        wait_idle();

        // fill all addresses back to back; writes must land every 2 cycles
        wr_cyc_q.delete();
        track_wr = 1'b1;
        for (int a = 0; a < 16; a++) send(1'b1, 4'(a), 16'(a * 16'h1111));
        wait_idle();
        track_wr = 1'b0;
        chk("wr_pulse_count", wr_cyc_q.size(), 16);
        bad = 0;
        for (int i = 1; i < wr_cyc_q.size(); i++)
            if (wr_cyc_q[i] - wr_cyc_q[i-1] != 2) bad++;
        chk("wr_spacing", bad, 0);
        for (int a = 0; a < 16; a++) send(1'b0, 4'(a), 16'h0000);
        wait_idle();

        // back-pressure: consumer stalled, queue fills to 4 behind one in flight
        rsp_mode = 1;
        repeat (2) @(negedge clk);
        n0 = rsp_count;
        for (int i = 0; i < 5; i++) send(1'b0, 4'(2 * i + 2), 16'h0000);
        repeat (4) @(negedge clk);
        chk("bp_req_ready", req_ready, 0);
        chk("bp_rsp_valid", rsp_valid, 1);
        chk("bp_rsp_rdata", rsp_rdata, 16'h2222);
        chk("bp_busy", busy, 1);
        rsp_mode = 0;
        send(1'b0, 4'd12, 16'h0000);
        wait_idle();
        chk("bp_rsp_count", rsp_count - n0, 6);

        // randomized traffic against the array model
        rsp_mode = 2;
        for (int i = 0; i < 80; i++) begin
            send(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 16'($urandom));
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        wait_idle();
        rsp_mode = 0;
        repeat (2) @(negedge clk);

        // reset while a read waits for RAM data with two reads queued
        send(1'b0, 4'd1, 16'h0000);
        send(1'b0, 4'd2, 16'h0000);
        send(1'b0, 4'd3, 16'h0000);
        rst = 1'b1;
        exp_q.delete();
        for (int i = 0; i < 16; i++) model_mem[i] = 16'h0000;
        n0 = rsp_count;
        chk("rst_cycle_en_read", ram_en_read, 0);
        chk("rst_cycle_en_write", ram_en_write, 0);
        @(negedge clk);
        chk("midrst_rsp_valid", rsp_valid, 0);
        chk("midrst_busy", busy, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("after_rst_busy", busy, 0);
        repeat (20) @(negedge clk);
        chk("after_rst_no_rsp", rsp_count - n0, 0);
        send(1'b0, 4'd5, 16'h0000);
        wait_idle();

`ifdef RAM_CTRL_STATS_EN
        reset_dut();
        for (int i = 0; i < 10; i++) send(1'b1, 4'(i), 16'(i + 100));
        for (int i = 0; i < 5; i++) send(1'b0, 4'(i), 16'h0000);
        wait_idle();
        chk("stat_wr_cnt", stat_wr_cnt, 10);
        chk("stat_rd_cnt", stat_rd_cnt, 5);
        force dut.stat_wr_q = 16'hFFFF;
        @(negedge clk);
        release dut.stat_wr_q;
        send(1'b1, 4'd9, 16'h0009);
        wait_idle();
        chk("stat_wr_sat", stat_wr_cnt, 16'hFFFF);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
